// File: rtl/imem_fetch_bridge_if.sv
// Fetch-side and SRAM port A signals of the instruction fetch bridge.
// master: core plus SRAM environment; slave: the bridge itself.
interface imem_fetch_bridge_if;
    logic        imem_read_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_rdata_o;
    logic        imem_done_o;
    logic        imem_fault_o;
    logic        mem_read_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] fetch_count_o;

    modport master (
        output imem_read_i, imem_addr_i, mem_rdata_i,
        input  imem_rdata_o, imem_done_o, imem_fault_o,
        input  mem_read_o, mem_addr_o, fetch_count_o
    );

    modport slave (
        input  imem_read_i, imem_addr_i, mem_rdata_i,
        output imem_rdata_o, imem_done_o, imem_fault_o,
        output mem_read_o, mem_addr_o, fetch_count_o
    );
endinterface

// File: rtl/imem_fetch_bridge.sv
// Converts the core's level-held fetch request into a single SRAM read strobe,
// waits a fixed latency, returns the word with a done pulse and counts fetches.
//
// state | meaning
// IDLE  | waiting for imem_read_i; latches address and checks for a fault
// REQ   | one-cycle SRAM read strobe, latency counter loaded
// WAIT  | counting down the SRAM latency, captures data at zero
// RESP  | done pulse with captured word, fetch counter increments
// FAULT | done pulse with fault flag, memory untouched
module imem_fetch_bridge #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned SIZE_BYTES  = 425984
) (
    input logic                clk,
    input logic                rst,
    imem_fetch_bridge_if.slave bus
);
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("imem_fetch_bridge: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [31:0] fetch_count;
    logic [3:0]  lat_cnt;
    logic        addr_fault;

    assign addr_fault = (bus.imem_addr_i[1:0] != 2'b00) ||
                        (bus.imem_addr_i >= 32'(SIZE_BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.imem_read_i) begin
                    state_nxt = addr_fault ? FAULT : REQ;
                end
            end
            REQ:   state_nxt = WAIT;
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP:  state_nxt = IDLE;
            FAULT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Faulted fetches clear the returned word so the core never sees stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rdata_q     <= '0;
            fetch_count <= '0;
            lat_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.imem_read_i) begin
                        addr_q <= bus.imem_addr_i;
                        if (addr_fault) begin
                            rdata_q <= '0;
                        end
                    end
                end
                REQ: lat_cnt <= 4'(MEM_LATENCY - 1);
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        rdata_q <= bus.mem_rdata_i;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: fetch_count <= fetch_count + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.mem_read_o    = (state == REQ);
    assign bus.mem_addr_o    = addr_q;
    assign bus.imem_done_o   = (state == RESP) || (state == FAULT);
    assign bus.imem_fault_o  = (state == FAULT);
    assign bus.imem_rdata_o  = rdata_q;
    assign bus.fetch_count_o = fetch_count;
endmodule

// File: tb/tb_imem_fetch_bridge.sv
// Bench for imem_fetch_bridge: two instances (latency 1 and 3) share core-side
// stimulus; a transaction-level model predicts every output on every cycle.
module tb_imem_fetch_bridge;
    localparam int unsigned SIZE_BYTES = 425984;
    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_read = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] sram_rdata [NDUT];

    logic        done  [NDUT];
    logic        fault [NDUT];
    logic        mread [NDUT];
    logic [31:0] rdata [NDUT];
    logic [31:0] maddr [NDUT];
    logic [31:0] count [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_fetch_bridge_if bus ();
        assign bus.imem_read_i = core_read;
        assign bus.imem_addr_i = core_addr;
        assign bus.mem_rdata_i = sram_rdata[g];
        assign done[g]  = bus.imem_done_o;
        assign fault[g] = bus.imem_fault_o;
        assign mread[g] = bus.mem_read_o;
        assign rdata[g] = bus.imem_rdata_o;
        assign maddr[g] = bus.mem_addr_o;
        assign count[g] = bus.fetch_count_o;
        imem_fetch_bridge #(
            .MEM_LATENCY((g == 0) ? 1 : 3),
            .SIZE_BYTES (SIZE_BYTES)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Transaction-level reference model, one slot per instance.
    bit          pend      [NDUT];
    bit          t_fault   [NDUT];
    int          t_read    [NDUT];
    int          t_done    [NDUT];
    logic [31:0] t_word    [NDUT];
    logic [31:0] exp_rdata [NDUT];
    logic [31:0] exp_count [NDUT];
    logic [31:0] exp_maddr [NDUT];
    bit          sram_vld  [NDUT];
    int          sram_due  [NDUT];
    logic [31:0] sram_addr [NDUT];
    int          mr_count  [NDUT];

    typedef struct {
        logic [31:0] addr;
        bit          exp_fault;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [9];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= SIZE_BYTES);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s cycle %0d: got no event, expected one within the cycle bound", nm, cyc);
    endtask

    task automatic model_advance(input int d, input logic r, input logic [31:0] a, input logic rs);
        bit idle;
        if (rs) begin
            pend[d]      = 1'b0;
            exp_rdata[d] = '0;
            exp_count[d] = '0;
            exp_maddr[d] = '0;
            return;
        end
        idle = !pend[d];
        if (pend[d]) begin
            if (cyc + 1 == t_done[d]) exp_rdata[d] = t_word[d];
            if (cyc == t_done[d]) begin
                if (!t_fault[d]) exp_count[d] = exp_count[d] + 32'd1;
                pend[d] = 1'b0;
            end
        end
        if (idle && r) begin
            pend[d]      = 1'b1;
            exp_maddr[d] = a;
            t_fault[d]   = is_fault(a);
            t_read[d]    = cyc + 1;
            t_done[d]    = t_fault[d] ? cyc + 1 : cyc + lat_of(d) + 2;
            t_word[d]    = t_fault[d] ? 32'h0 : mem_word(a);
            if (t_fault[d]) exp_rdata[d] = '0;
        end
    endtask

    task automatic observe();
        for (int d = 0; d < NDUT; d++) begin
            bit exp_mr;
            bit exp_dn;
            exp_mr = pend[d] && !t_fault[d] && (cyc == t_read[d]);
            exp_dn = pend[d] && (cyc == t_done[d]);
            chk("mem_read", d, 32'(mread[d]), 32'(exp_mr));
            chk("done",     d, 32'(done[d]),  32'(exp_dn));
            chk("fault",    d, 32'(fault[d]), 32'(exp_dn && t_fault[d]));
            chk("rdata",    d, rdata[d], exp_rdata[d]);
            chk("mem_addr", d, maddr[d], exp_maddr[d]);
            chk("count",    d, count[d], exp_count[d]);
            // SRAM: word valid exactly MEM_LATENCY cycles after the strobe, junk otherwise.
            if (sram_vld[d] && sram_due[d] == cyc) begin
                sram_rdata[d] = mem_word(sram_addr[d]);
                sram_vld[d]   = 1'b0;
            end else begin
                sram_rdata[d] = $urandom;
            end
            if (mread[d] === 1'b1) begin
                sram_vld[d]  = 1'b1;
                sram_due[d]  = cyc + lat_of(d);
                sram_addr[d] = maddr[d];
                mr_count[d]++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] a, input logic rs);
        core_read = r;
        core_addr = a;
        rst       = rs;
        for (int d = 0; d < NDUT; d++) model_advance(d, r, a, rs);
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int c0;
        int mr_at;
        int dn_at;
        int ndone;
        int dones [3];
        int mr_base;
        bit got;
        logic [31:0] a;

        for (int d = 0; d < NDUT; d++) begin
            sram_rdata[d] = '0;
            pend[d] = 1'b0;
            t_fault[d] = 1'b0;
            t_read[d] = 0;
            t_done[d] = 0;
            t_word[d] = '0;
            exp_rdata[d] = '0;
            exp_count[d] = '0;
            exp_maddr[d] = '0;
            sram_vld[d] = 1'b0;
            sram_due[d] = 0;
            sram_addr[d] = '0;
            mr_count[d] = 0;
        end

        vecs[0] = '{32'h0000_0100, 1'b0, 32'h0050_0093};
        vecs[1] = '{32'h0000_0102, 1'b1, 32'h0};
        vecs[2] = '{32'h0006_8000, 1'b1, 32'h0};
        vecs[3] = '{32'h0006_7FFC, 1'b0, mem_word(32'h0006_7FFC)};
        vecs[4] = '{32'h0006_7FFE, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_0000, 1'b0, mem_word(32'h0000_0000)};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_1003, 1'b1, 32'h0};
        vecs[8] = '{32'h0000_0004, 1'b0, mem_word(32'h0000_0004)};

        // Reset then idle.
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        idle_cycles(10);
        chk("idle_no_strobe", 0, 32'(mr_count[0]), 32'd0);
        chk("idle_no_strobe", 1, 32'(mr_count[1]), 32'd0);

        // Single fetch at latency 1.
        c0 = cyc; mr_at = -1; dn_at = -1;
        for (int k = 0; k < 8; k++) begin
            cycle(dn_at < 0, 32'h100, 1'b0);
            if (mread[0] === 1'b1 && mr_at < 0) mr_at = cyc - c0;
            if (done[0] === 1'b1 && dn_at < 0) begin
                dn_at = cyc - c0;
                chk("single_rdata", 0, rdata[0], 32'h0050_0093);
            end
        end
        chk("single_strobe_cycle", 0, 32'(mr_at), 32'd1);
        chk("single_done_cycle", 0, 32'(dn_at), 32'd3);
        chk("single_count", 0, count[0], 32'd1);

        // Table of addresses, each held until done on the latency-1 instance.
        for (int i = 0; i < 9; i++) begin
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                cycle(1'b1, vecs[i].addr, 1'b0);
                if (done[0] === 1'b1) begin
                    got = 1'b1;
                    chk("vec_fault", 0, 32'(fault[0]), 32'(vecs[i].exp_fault));
                    chk("vec_rdata", 0, rdata[0], vecs[i].exp_rdata);
                end
            end
            if (!got) fail_now("vec_timeout");
            idle_cycles(6);
        end

        // Back-to-back on the latency-3 instance.
        cycle(1'b0, 32'h0, 1'b1);
        idle_cycles(2);
        c0 = cyc; ndone = 0; mr_base = mr_count[1];
        for (int k = 0; k < 18; k++) begin
            cycle(ndone < 3, 32'(4 * ndone), 1'b0);
            if (done[1] === 1'b1 && ndone < 3) begin
                dones[ndone] = cyc - c0;
                ndone++;
            end
        end
        idle_cycles(6);
        chk("b2b_ndone", 1, 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("b2b_done0", 1, 32'(dones[0]), 32'd5);
            chk("b2b_done1", 1, 32'(dones[1]), 32'd11);
            chk("b2b_done2", 1, 32'(dones[2]), 32'd17);
        end
        chk("b2b_strobes", 1, 32'(mr_count[1] - mr_base), 32'd3);
        chk("b2b_count", 1, count[1], 32'd3);

        // Reset during WAIT discards the fetch.
        cycle(1'b0, 32'h0, 1'b1);
        idle_cycles(2);
        cycle(1'b1, 32'h20, 1'b0);
        cycle(1'b1, 32'h20, 1'b0);
        cycle(1'b1, 32'h20, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 32'h0, 1'b0);
            if (done[1] === 1'b1) got = 1'b1;
        end
        chk("midreset_no_done", 1, 32'(got), 32'd0);
        chk("midreset_count", 1, count[1], 32'd0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(1'b1, 32'h24, 1'b0);
            if (done[1] === 1'b1) begin
                got = 1'b1;
                chk("after_reset_rdata", 1, rdata[1], mem_word(32'h24));
                chk("after_reset_fault", 1, 32'(fault[1]), 32'd0);
            end
        end
        if (!got) fail_now("after_reset_timeout");
        idle_cycles(6);

        // Counter wrap on the latency-1 instance.
        force g_dut[0].dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release g_dut[0].dut.fetch_count;
        exp_count[0] = 32'hFFFF_FFFF;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(1'b1, 32'h8, 1'b0);
            if (done[0] === 1'b1) got = 1'b1;
        end
        if (!got) fail_now("wrap_timeout");
        idle_cycles(2);
        chk("wrap_count", 0, count[0], 32'h0);
        idle_cycles(6);

        // Randomized traffic, including dropped requests and occasional reset.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0: a = 32'($urandom_range(0, 3));
                1: a = SIZE_BYTES - 32'($urandom_range(0, 2) * 4);
                2: a = $urandom;
                default: a = 32'($urandom_range(0, 255) * 4);
            endcase
            cycle($urandom_range(0, 9) < 7, a, $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imem_fetch_bridge.md
Name: imem_fetch_bridge

Overview:
- Sits between the core's instruction-fetch port (imem_read/imem_addr/imem_rdata/imem_done) and port A of the unified SRAM (read/addr/rdata).
- Turns the core's level-held fetch request into a one-cycle SRAM read strobe and waits a fixed memory latency.
- Captures the returned word and answers with a one-cycle done pulse.
- Flags misaligned or out-of-range fetches without touching memory, and counts completed fetches for performance monitoring.

Parameters:
- MEM_LATENCY, 1, cycles from the cycle mem_read_o is high to the cycle mem_rdata_i is valid; legal range 1..15.
- SIZE_BYTES, 425984, SRAM size in bytes; fetch addresses >= SIZE_BYTES fault.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_read_i  input  1  core fetch request; held high with stable address until imem_done_o.
- imem_addr_i  input  32  byte address of the instruction.
- imem_rdata_o  output  32  fetched instruction; valid while imem_done_o=1.
- imem_done_o  output  1  one-cycle completion pulse.
- imem_fault_o  output  1  high with imem_done_o when the fetch faulted.
- mem_read_o  output  1  SRAM port A read strobe, exactly one cycle per fetch.
- mem_addr_o  output  32  SRAM port A address; registered, stable from the REQ cycle until return to IDLE.
- mem_rdata_i  input  32  SRAM port A read data.
- fetch_count_o  output  32  number of completed non-fault fetches.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of current state:
  - State goes to IDLE.
  - Outputs clear: imem_rdata_o=0, imem_done_o=0, imem_fault_o=0, mem_read_o=0, mem_addr_o=0, fetch_count_o=0, latency counter=0.
  - An in-flight SRAM read is discarded and no done pulse follows.
- FSM states: IDLE, REQ, WAIT, RESP, FAULT. All outputs are registered or decoded from state only; no combinational path from imem_* inputs to any output.
- IDLE, imem_read_i=0: stay in IDLE.
- IDLE, imem_read_i=1: latch imem_addr_i into the address register. A fault exists if addr[1:0]!=0 or addr>=SIZE_BYTES.
  - Fault: go to FAULT.
  - No fault: go to REQ.
- REQ: mem_read_o=1 for exactly this cycle; load counter with MEM_LATENCY-1; go to WAIT.
- WAIT: hold mem_addr_o.
  - Counter=0: capture mem_rdata_i into imem_rdata_o; go to RESP.
  - Otherwise: decrement the counter.
- RESP: imem_done_o=1, imem_fault_o=0; fetch_count_o increments by 1 (wraps 0xFFFFFFFF->0); go to IDLE.
- FAULT: imem_done_o=1, imem_fault_o=1, imem_rdata_o=0, mem_read_o stays 0, fetch_count_o unchanged; go to IDLE.
- Latency: request first seen in cycle 0.
  - Normal fetch: mem_read_o in cycle 1, done in cycle MEM_LATENCY+2.
  - Fault: done in cycle 1.
- Back-to-back: imem_read_i is ignored in the RESP and FAULT cycles. A request still high in the following IDLE cycle is treated as a new fetch, so steady-state throughput is one fetch per MEM_LATENCY+3 cycles.
- Request dropped mid-flight (imem_read_i=0 during REQ or WAIT): the transaction still completes and done still pulses; the core must ignore it.
- Address changes mid-flight are ignored; the latched address is used.
- Outside RESP, imem_rdata_o holds the last captured word or 0 after a fault.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, imem_read_i=0 for 10 cycles -> all outputs 0; mem_read_o never asserted.
- Single fetch, MEM_LATENCY=1: addr=0x00000100 requested at cycle 0, SRAM model returns 0x00500093 -> mem_read_o=1 only in cycle 1 with mem_addr_o=0x100; imem_done_o=1 only in cycle 3 with imem_rdata_o=0x00500093; fetch_count_o=1.
- Misaligned and out-of-range: addr=0x00000102, then addr=0x00068000 (=425984) -> each gives done=1 and fault=1 one cycle after the request; mem_read_o stays 0; rdata=0; fetch_count_o unchanged.
- Back-to-back with MEM_LATENCY=3, imem_read_i held high through addresses 0x0, 0x4, 0x8 -> done pulses at cycles 5, 11, 17; fetch_count_o=3; exactly three mem_read_o pulses.
- Reset mid-operation: rst=1 in the WAIT cycle of a fetch -> no done pulse; state returns to IDLE; fetch_count_o=0; the next fetch completes normally.
- Counter wrap: force fetch_count_o to 0xFFFFFFFF, complete one fetch -> fetch_count_o becomes 0x00000000.
